// File: rtl/ras_ctrl.sv
// Return-address stack controller.
// Circular array with wrapping top pointer; pushes on a full stack overwrite
// the oldest entry. A one-entry backup of the last popped value lets a
// misprediction flush undo a pop even after a later push reused that slot.
module ras_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     PL_stall_ex,
    input  logic                     PL_flush,
    input  logic                     RAS_push,
    input  logic                     RAS_pop,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     RAS_rollback_pop_id,
    input  logic                     RAS_rollback_push_id,
    input  logic                     RAS_rollback_push_ex,
    output logic [WIDTH-1:0]         top_data,
    output logic                     ras_valid,
    output logic                     ras_full,
    output logic [$clog2(DEPTH):0]   ras_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [AW-1:0] TP_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    tp_q, tp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] bkp_q, bkp_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic signed [2:0]    adj;
    logic [CW+1:0]        adj_ext;
    logic signed [CW+1:0] cnt_sum;

    // Net flush adjustment (-2..+1) and the unclamped count it produces.
    always_comb begin
        adj     = $signed({2'b00, RAS_rollback_pop_id})
                - $signed({2'b00, RAS_rollback_push_id})
                - $signed({2'b00, RAS_rollback_push_ex});
        adj_ext = {{(CW-1){adj[2]}}, adj};
        cnt_sum = $signed({2'b00, cnt_q}) + $signed(adj_ext);
    end

    // Next-state selection: stall freezes, flush rolls back, else IF push/pop.
    always_comb begin
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        bkp_d   = bkp_q;
        wr_en   = 1'b0;
        wr_addr = tp_q;
        wr_data = push_data;
        if (!PL_stall_ex) begin
            if (PL_flush) begin
                tp_d = tp_q + adj_ext[AW-1:0];
                if (cnt_sum < 0)
                    cnt_d = '0;
                else if (cnt_sum > $signed({2'b00, CNT_MAX}))
                    cnt_d = CNT_MAX;
                else
                    cnt_d = cnt_sum[CW-1:0];
                if (RAS_rollback_pop_id) begin
                    wr_en   = 1'b1;
                    wr_addr = tp_q + adj_ext[AW-1:0];
                    wr_data = bkp_q;
                end
            end else if (RAS_push && RAS_pop) begin
                // jalr that returns and calls: replace the top in place
                wr_en   = 1'b1;
                wr_addr = tp_q;
                bkp_d   = mem_q[tp_q];
            end else if (RAS_push) begin
                tp_d    = tp_q + TP_ONE;
                wr_en   = 1'b1;
                wr_addr = tp_q + TP_ONE;
                cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else if (RAS_pop && (cnt_q != '0)) begin
                bkp_d = mem_q[tp_q];
                tp_d  = tp_q - TP_ONE;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State and storage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q  <= '0;
            cnt_q <= '0;
            bkp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            bkp_q <= bkp_d;
            if (wr_en) mem_q[wr_addr] <= wr_data;
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        top_data  = (cnt_q != '0) ? mem_q[tp_q] : '0;
        ras_valid = (cnt_q != '0);
        ras_full  = (cnt_q == CNT_MAX);
        ras_count = cnt_q;
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl (DEPTH=8, WIDTH=32).
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PL_stall_ex, PL_flush, RAS_push, RAS_pop;
    logic [31:0] push_data;
    logic        RAS_rollback_pop_id, RAS_rollback_push_id, RAS_rollback_push_ex;
    logic [31:0] top_data;
    logic        ras_valid, ras_full;
    logic [3:0]  ras_count;

    int n_checks = 0;
    int n_errors = 0;

    ras_ctrl #(.DEPTH(8), .WIDTH(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .PL_stall_ex          (PL_stall_ex),
        .PL_flush             (PL_flush),
        .RAS_push             (RAS_push),
        .RAS_pop              (RAS_pop),
        .push_data            (push_data),
        .RAS_rollback_pop_id  (RAS_rollback_pop_id),
        .RAS_rollback_push_id (RAS_rollback_push_id),
        .RAS_rollback_push_ex (RAS_rollback_push_ex),
        .top_data             (top_data),
        .ras_valid            (ras_valid),
        .ras_full             (ras_full),
        .ras_count            (ras_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] top, input logic [3:0] cnt);
        chk({tag, ".top"},   top_data,  top);
        chk({tag, ".count"}, {28'd0, ras_count}, {28'd0, cnt});
        chk({tag, ".valid"}, {31'd0, ras_valid}, {31'd0, cnt != 0});
        chk({tag, ".full"},  {31'd0, ras_full},  {31'd0, cnt == 4'd8});
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge with inputs idle.
    task automatic cyc(input logic st, input logic fl, input logic pu, input logic po,
                       input logic [31:0] d, input logic rp, input logic ri, input logic re);
        PL_stall_ex = st; PL_flush = fl; RAS_push = pu; RAS_pop = po; push_data = d;
        RAS_rollback_pop_id = rp; RAS_rollback_push_id = ri; RAS_rollback_push_ex = re;
        @(posedge clk); #1;
        PL_stall_ex = 0; PL_flush = 0; RAS_push = 0; RAS_pop = 0; push_data = 0;
        RAS_rollback_pop_id = 0; RAS_rollback_push_id = 0; RAS_rollback_push_ex = 0;
    endtask

    task automatic push(input logic [31:0] d); cyc(0, 0, 1, 0, d, 0, 0, 0); endtask
    task automatic pop();                      cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        PL_stall_ex = 0; PL_flush = 0; RAS_push = 0; RAS_pop = 0; push_data = 0;
        RAS_rollback_pop_id = 0; RAS_rollback_push_id = 0; RAS_rollback_push_ex = 0;
        rst_n = 1'b0;
        #12;
        chk_state("reset", 32'h0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic push/pop
        push(32'h100); push(32'h200); push(32'h300);
        chk_state("push3", 32'h300, 4'd3);
        pop(); pop();
        chk_state("pop2", 32'h100, 4'd1);
        pop();
        chk_state("pop_to_empty", 32'h0, 4'd0);

        // overflow wrap and full drain
        do_reset();
        for (int i = 1; i <= 9; i++) push(32'(i * 16));
        chk_state("wrap9", 32'h90, 4'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_top", top_data, 32'(32'h90 - i * 16));
            pop();
        end
        chk_state("drained", 32'h0, 4'd0);
        pop();
        chk_state("pop_empty", 32'h0, 4'd0);
        push(32'hABC);
        chk_state("push_after_empty", 32'hABC, 4'd1);

        // undo pop after a later push overwrote the slot
        do_reset();
        push(32'h100); push(32'h200); pop(); push(32'h500);
        chk_state("pre_flush", 32'h500, 4'd2);
        cyc(0, 1, 0, 0, 0, 1, 0, 1);
        chk_state("flush_pop_ex", 32'h200, 4'd2);
        pop();
        chk_state("flush_pop_ex_below", 32'h100, 4'd1);

        // combined push+pop, then undo
        do_reset();
        push(32'h100); push(32'h200);
        cyc(0, 0, 1, 1, 32'h444, 0, 0, 0);
        chk_state("pushpop", 32'h444, 4'd2);
        cyc(0, 1, 0, 0, 0, 1, 1, 0);
        chk_state("flush_pop_id", 32'h200, 4'd2);

        // undo a push, then clamp at zero
        cyc(0, 1, 1, 1, 32'h777, 0, 1, 0);
        chk_state("flush_push_id", 32'h100, 4'd1);
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        chk_state("flush_clamp0", 32'h0, 4'd0);

        // clamp at DEPTH
        do_reset();
        for (int i = 1; i <= 8; i++) push(32'(i));
        pop(); push(32'h99);
        chk_state("refill", 32'h99, 4'd8);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        chk_state("flush_clamp8", 32'h8, 4'd8);

        // stall and no-op flush
        do_reset();
        push(32'h100); push(32'h200);
        cyc(1, 0, 1, 0, 32'h999, 0, 0, 0);
        chk_state("stall_push", 32'h200, 4'd2);
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        chk_state("stall_pop", 32'h200, 4'd2);
        cyc(0, 1, 1, 0, 32'h999, 0, 0, 0);
        chk_state("flush_norb", 32'h200, 4'd2);
        cyc(1, 1, 0, 0, 0, 0, 1, 1);
        chk_state("stall_flush", 32'h200, 4'd2);
        @(posedge clk); #1;
        chk_state("stall_flush_lost", 32'h200, 4'd2);

        // asynchronous reset mid-operation
        push(32'h300);
        chk_state("pre_rst", 32'h300, 4'd3);
        @(negedge clk); #1;
        RAS_push = 1; push_data = 32'hDEAD;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, 4'd0);
        @(posedge clk); #1;
        chk_state("rst_hold", 32'h0, 4'd0);
        RAS_push = 0; push_data = 0;
        rst_n = 1'b1;
        push(32'h123);
        chk_state("push_after_rst", 32'h123, 4'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 Parameter DEPTH, 8, number of return-address entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, 32, return-address width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PL_stall_ex  input  1  pipeline stall; while high, all stack operations SHALL be frozen.
REQ-006 PL_flush  input  1  misprediction flush; while high, the rollback requests below SHALL be applied.
REQ-007 RAS_push  input  1  IF-stage call: push push_data.
REQ-008 RAS_pop  input  1  IF-stage return: pop the top entry.
REQ-009 push_data  input  WIDTH  return address to push (pc_add_4).
REQ-010 RAS_rollback_pop_id  input  1  the ID-stage instruction popped and must be undone.
REQ-011 RAS_rollback_push_id  input  1  the ID-stage instruction pushed and must be undone.
REQ-012 RAS_rollback_push_ex  input  1  the EX-stage instruction pushed and must be undone.
REQ-013 top_data  output  WIDTH  current top entry (jalr_prediction_result), read combinationally.
REQ-014 ras_valid  output  1  count != 0.
REQ-015 ras_full  output  1  count == DEPTH.
REQ-016 ras_count  output  clog2(DEPTH)+1  number of live entries.

Function
REQ-017 Storage SHALL be a circular array mem[DEPTH] with a top pointer tp (clog2(DEPTH) bits, wrapping modulo DEPTH) and a count cnt in the range 0..DEPTH.
REQ-018 top_data SHALL equal mem[tp] when cnt != 0, and 0 when cnt == 0.
REQ-019 Operation priority each cycle SHALL be: PL_stall_ex (hold everything), then PL_flush (rollback only), then IF push/pop.
REQ-020 Push only: tp <= tp+1; mem[tp+1] <= push_data; cnt <= min(cnt+1, DEPTH).
REQ-021 Push on full SHALL overwrite the oldest entry through wrap-around; cnt stays at DEPTH.
REQ-022 Pop only, cnt != 0: bkp_data <= mem[tp]; tp <= tp-1; cnt <= cnt-1.
REQ-023 Pop on empty SHALL change no state.
REQ-024 Push and pop together (jalr that is both a return and a call): mem[tp] <= push_data; bkp_data <= old mem[tp]; tp and cnt unchanged.
REQ-025 bkp_data SHALL be a WIDTH-bit backup of the last popped value, written only by REQ-022 and REQ-024.
REQ-026 Flush: the net adjustment SHALL be n = rollback_pop_id - rollback_push_id - rollback_push_ex, in the range -2..+1.
REQ-027 On flush, tp <= tp+n (modulo DEPTH) and cnt <= clamp(cnt+n, 0, DEPTH).
REQ-028 On flush with rollback_pop_id high, mem[new tp] <= bkp_data, restoring the popped entry even if a later push overwrote it.
REQ-029 On flush, RAS_push and RAS_pop SHALL be ignored that cycle.
REQ-030 Flush with all rollback inputs low SHALL change no state.
REQ-031 Flush and PL_stall_ex together: stall wins; the rollback SHALL be lost unless flush is still asserted after the stall drops.
REQ-032 Latency: a push or pop is visible on top_data in the cycle after the edge; there is no combinational path from push_data to top_data.
REQ-033 ras_valid, ras_full and ras_count SHALL be derived from registered cnt only.

Reset
REQ-034 While rst_n is low, asynchronously: tp=0, cnt=0, bkp_data=0, all mem entries 0.
REQ-035 After reset: top_data=0, ras_valid=0, ras_full=0, ras_count=0.
REQ-036 Reset asserted mid-operation SHALL discard any in-flight push, pop or rollback; no partial update.

Verification
REQ-037 Push 0x100, 0x200, 0x300 -> top_data 0x300, ras_count 3; pop twice -> top_data 0x100, ras_count 1.
REQ-038 DEPTH=8: push 0x10..0x90 (9 pushes) -> ras_full=1, count 8, top 0x90; 8 pops -> last value popped is 0x20, ras_valid=0; a further pop changes nothing.
REQ-039 Stack {0x100, 0x200}: pop, push 0x500, then flush with rollback_pop_id=1 and rollback_push_ex=1 -> top_data 0x200, count 2.
REQ-040 Push and pop together with push_data 0x444 on top 0x200 -> top 0x444, count unchanged; flush with rollback_pop_id=1 and rollback_push_id=1 -> top 0x200.
REQ-041 Push asserted with PL_stall_ex=1 -> no change; push and flush together (no rollback) -> no change.
REQ-042 Reset pulsed after 3 pushes -> all outputs 0 immediately; first push after reset -> count 1.
